alu_hilo_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit that sits on the driving end of the ALU port (ctrl/a/b out, r/r2/z in), alongside the datapath.
- It owns the architectural HI/LO registers.
- Multiplies are issued to the ALU's unsigned-multiply operation (ctrl 0x13), and the 64-bit {r2,r} product is captured.
- Divides run as a 32-step restoring algorithm that uses the ALU subtract operation (ctrl 0x06) every step.
- Sign handling (MULT/DIV) and the MTHI/MTLO writes are done locally.

---
 rtl/alu_hilo_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_alu_hilo_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_hilo_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that drives an external combinational
// ALU and owns the architectural HI/LO registers.
module alu_hilo_sequencer #(
  parameter int          DIV_STEPS  = 32,
  parameter logic [5:0]  CTRL_MULTU = 6'h13,
  parameter logic [5:0]  CTRL_SUB   = 6'h06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [5:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_r2,
  input  logic        alu_z
);

  localparam int SW = $clog2(DIV_STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(DIV_STEPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic          sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
  logic [63:0]   prod_q, prod_d;
  logic [31:0]   rem_q, rem_d, quo_q, quo_d;
  logic [SW-1:0] step_q, step_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          dbz_q, dbz_d;

  logic          unused_z;
  assign unused_z = alu_z;

  // Partial remainder is kept as 32 bits: its bit 32 is always zero after a step,
  // so only the shifted value needs the full 33-bit compare.
  logic [32:0] rsh;
  logic [31:0] qsh;
  logic        rge;
  logic        is_signed, neg_res;
  logic [63:0] prod_fix;

  assign rsh       = {rem_q, quo_q[31]};
  assign qsh       = {quo_q[30:0], 1'b0};
  assign rge       = rsh >= {1'b0, mag_b_q};
  assign is_signed = op_q[0];
  assign neg_res   = is_signed & (sgn_a_q ^ sgn_b_q);
  assign prod_fix  = neg_res ? -prod_q : prod_q;

  always_comb begin
    alu_ctrl = 6'd0;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    case (state_q)
      S_MUL: begin
        alu_ctrl = CTRL_MULTU;
        alu_a    = mag_a_q;
        alu_b    = mag_b_q;
      end
      S_DIV: begin
        alu_ctrl = CTRL_SUB;
        alu_a    = rsh[31:0];
        alu_b    = mag_b_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    step_d  = step_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          sgn_a_d = src_a[31];
          sgn_b_d = src_b[31];
          mag_a_d = (op[0] && src_a[31]) ? -src_a : src_a;
          mag_b_d = (op[0] && src_b[31]) ? -src_b : src_b;
          dbz_d   = 1'b0;
          rem_d   = 32'd0;
          quo_d   = (op[0] && src_a[31]) ? -src_a : src_a;
          step_d  = '0;
          if (!op[1])               state_d = S_MUL;
          else if (src_b != 32'd0)  state_d = S_DIV;
          else begin
            state_d = S_FIX;
            dbz_d   = 1'b1;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_MUL: begin
        prod_d  = {alu_r2, alu_r};
        state_d = S_FIX;
      end
      S_DIV: begin
        rem_d  = rge ? alu_r : rsh[31:0];
        quo_d  = {qsh[31:1], rge};
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        // HI/LO commit on the edge into DONE; a zero divisor leaves them untouched.
        if (!op_q[1]) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (!dbz_q) begin
          lo_d = neg_res ? -quo_q : quo_q;
          hi_d = (is_signed && sgn_a_q) ? -rem_q : rem_q;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      mag_a_q <= 32'd0;
      mag_b_q <= 32'd0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      prod_q  <= 64'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      step_q  <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      step_q  <= step_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_hilo_sequencer.sv
// Scoreboard bench for alu_hilo_sequencer: stimulus pushes expected HI/LO/dbz,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_hilo_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_r, alu_r2;
  logic        alu_z;

  always #5 clk = ~clk;

  // Reference combinational ALU
  logic [63:0] mprod;
  always_comb begin
    mprod  = {32'd0, alu_a} * {32'd0, alu_b};
    alu_r  = 32'd0;
    alu_r2 = 32'd0;
    if (alu_ctrl == 6'h13) begin
      alu_r  = mprod[31:0];
      alu_r2 = mprod[63:32];
    end else if (alu_ctrl == 6'h06) begin
      alu_r  = alu_a - alu_b;
    end
    alu_z = (alu_r == 32'd0);
  end

  alu_hilo_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_r2(alu_r2), .alu_z(alu_z)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_hi", hi, e.hi);
        chk("sb_lo", lo, e.lo);
        chk("sb_dbz", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  // One operation: push expectation, check ALU ctrl in the first busy cycle,
  // latency to done, and busy dropping after DONE.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz, input int lat, input logic [5:0] ectrl,
                       input logic mthi_at_start, input logic mtlo_busy);
    exp_t e;
    logic [31:0] lo_before;
    int k;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    sb.push_back(e);
    @(posedge clk); #1;
    lo_before = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (mthi_at_start) begin mthi = 1'b1; wdata = 32'h0000_0099; end
    @(posedge clk); #1;  // E0
    start = 1'b0; mthi = 1'b0;
    chk({name, "_busy0"}, {31'd0, busy}, 32'd1);
    chk({name, "_ctrl"}, {26'd0, alu_ctrl}, {26'd0, ectrl});
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (mtlo_busy && k == 3) begin mtlo = 1'b1; wdata = 32'h0000_0BAD; end
      if (mtlo_busy && k == 4) begin
        mtlo = 1'b0;
        chk({name, "_lo_busy_hold"}, lo, lo_before);
      end
    end
    chk({name, "_latency"}, k, lat);
    chk({name, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    chk("rst_alu", {26'd0, alu_ctrl} | alu_a | alu_b, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2,  6'h13, 1'b0, 1'b0);
    issue("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 2,  6'h13, 1'b0, 1'b0);
    issue("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 2,  6'h13, 1'b0, 1'b0);
    issue("divu_100_7",2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33, 6'h06, 1'b0, 1'b1);
    issue("div_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 6'h06, 1'b0, 1'b0);
    issue("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 6'h06, 1'b0, 1'b0);

    // Preload HI/LO, then divide by zero with mthi asserted alongside start
    @(posedge clk); #1; mthi = 1'b1; wdata = 32'h11;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b1; wdata = 32'h22;
    @(posedge clk); #1; mtlo = 1'b0;
    chk("mthi_wr", hi, 32'h11);
    chk("mtlo_wr", lo, 32'h22);
    issue("div_zero",  2'b11, 32'd1234,      32'd0,         32'h11,        32'h22,        1'b1, 1,  6'h00, 1'b1, 1'b0);
    chk("dbz_sticky", {31'd0, div_by_zero}, 32'd1);
    issue("multu_clr", 2'b00, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 2,  6'h13, 1'b0, 1'b0);

    @(posedge clk); #1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", hi, 32'h55);
    chk("mt_both_lo", lo, 32'h55);

    // Abort a DIVU partway through with reset
    @(posedge clk); #1; start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #1; reset = 1'b1;
    #2;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_flags", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    issue("divu_9_3",  2'b10, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0, 33, 6'h06, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
